// File: rtl/udp_axis_master.sv
// UDP RX to AXI-Stream bridge: filters datagrams on destination IP/port, strips a
// 4-byte transfer ID, packs the payload into one word and tracks ID continuity.
module udp_axis_master #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [15:0] UDP_PORT   = 16'd1234,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0180
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  hdr_valid,
  output logic                  hdr_ready,
  input  logic [31:0]           hdr_dest_ip,
  input  logic [15:0]           hdr_dest_port,
  input  logic [7:0]            pl_tdata,
  input  logic                  pl_tvalid,
  output logic                  pl_tready,
  input  logic                  pl_tlast,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic                  out_tlast,
  output logic [31:0]           rx_id,
  output logic                  seq_gap,
  output logic [15:0]           drop_count
);

  localparam int N = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, ID, DATA, DROP, OUT} state_t;

  state_t                  state;
  logic [6:0]              byte_cnt;
  logic [31:0]             id_reg;
  logic [DATA_WIDTH-1:0]   word_reg;
  logic [31:0]             expected;
  logic                    first_seen;

  logic hdr_fire;
  logic pl_fire;
  logic hdr_match;

  assign hdr_fire  = hdr_valid & hdr_ready;
  assign pl_fire   = pl_tvalid & pl_tready;
  assign hdr_match = (hdr_dest_ip == LOCAL_IP) && (hdr_dest_port == UDP_PORT);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Bytes arrive little-endian: each new byte enters at the top and the word
  // shifts down, so the first byte ends up in bits [7:0].
  function automatic logic [DATA_WIDTH-1:0] shift_byte(input logic [DATA_WIDTH-1:0] w,
                                                       input logic [7:0] b);
    logic [DATA_WIDTH+7:0] t;
    t = {b, w} >> 8;
    return t[DATA_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      id_reg     <= '0;
      word_reg   <= '0;
      expected   <= '0;
      first_seen <= 1'b0;
      hdr_ready  <= 1'b0;
      pl_tready  <= 1'b0;
      out_tdata  <= '0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      rx_id      <= '0;
      seq_gap    <= 1'b0;
      drop_count <= '0;
    end else begin
      seq_gap <= 1'b0;
      case (state)
        IDLE: begin
          if (hdr_fire) begin
            hdr_ready <= 1'b0;
            pl_tready <= 1'b1;
            byte_cnt  <= '0;
            if (hdr_match) begin
              state <= ID;
            end else begin
              state      <= DROP;
              drop_count <= sat_inc(drop_count);
            end
          end else begin
            hdr_ready <= 1'b1;
          end
        end
        ID: begin
          if (pl_fire) begin
            id_reg <= {pl_tdata, id_reg[31:8]};
            if (pl_tlast) begin
              state      <= IDLE;
              pl_tready  <= 1'b0;
              hdr_ready  <= 1'b1;
              drop_count <= sat_inc(drop_count);
            end else if (byte_cnt == 7'd3) begin
              state    <= DATA;
              byte_cnt <= '0;
            end else begin
              byte_cnt <= byte_cnt + 7'd1;
            end
          end
        end
        DATA: begin
          if (pl_fire) begin
            word_reg <= shift_byte(word_reg, pl_tdata);
            if (byte_cnt == 7'(N - 1)) begin
              if (pl_tlast) begin
                state      <= OUT;
                pl_tready  <= 1'b0;
                out_tdata  <= shift_byte(word_reg, pl_tdata);
                out_tvalid <= 1'b1;
                out_tlast  <= 1'b1;
                rx_id      <= id_reg;
                seq_gap    <= first_seen && (id_reg != expected);
                expected   <= id_reg + 32'd1;
                first_seen <= 1'b1;
              end else begin
                state      <= DROP;
                drop_count <= sat_inc(drop_count);
              end
            end else if (pl_tlast) begin
              state      <= IDLE;
              pl_tready  <= 1'b0;
              hdr_ready  <= 1'b1;
              drop_count <= sat_inc(drop_count);
            end else begin
              byte_cnt <= byte_cnt + 7'd1;
            end
          end
        end
        DROP: begin
          if (pl_fire && pl_tlast) begin
            state     <= IDLE;
            pl_tready <= 1'b0;
            hdr_ready <= 1'b1;
          end
        end
        OUT: begin
          if (out_tready) begin
            state      <= IDLE;
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            hdr_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          hdr_ready  <= 1'b0;
          pl_tready  <= 1'b0;
          out_tvalid <= 1'b0;
          out_tlast  <= 1'b0;
        end
      endcase
    end
  end

endmodule
